// File: rtl/exec_instr_gen_mul_pkg.sv
// exec_instr_gen_mul_pkg: shared widths, tag sizing and pipeline stage entry type for the shared multiplier arbiter
package exec_instr_gen_mul_pkg;
    localparam int OP_WIDTH_DEF = 16;
    localparam int P_WIDTH_DEF  = 2 * OP_WIDTH_DEF;
    localparam int MAX_REQ      = 8;
    // Tag is sized for the largest legal requester count so one entry type serves every NUM_REQ.
    localparam int TAG_W        = $clog2(MAX_REQ);

    // One pipeline stage: S1 payload is {a, b}, S2 payload is the product; both are 2*OP_WIDTH wide.
    typedef struct packed {
        logic                   valid;
        logic [TAG_W-1:0]       tag;
        logic [P_WIDTH_DEF-1:0] payload;
    } stage_t;

    function automatic logic [MAX_REQ-1:0] tag_onehot(input logic [TAG_W-1:0] t);
        return MAX_REQ'(1) << t;
    endfunction
endpackage

// File: rtl/ExecInstrGen_mul_mul_16ns_16ns_32_1_1.sv
// ExecInstrGen_mul_mul_16ns_16ns_32_1_1: combinational signed multiplier wrapper
//   din0 : operand A (two's complement)
//   din1 : operand B (two's complement)
//   dout : full-width signed product
module ExecInstrGen_mul_mul_16ns_16ns_32_1_1 #(
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 16,
    parameter int dout_WIDTH = 32
) (
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout
);
    logic signed [dout_WIDTH-1:0] ext0, ext1;

    // Sign-extend to the product width first so the multiply keeps every product bit.
    assign ext0 = dout_WIDTH'($signed(din0));
    assign ext1 = dout_WIDTH'($signed(din1));
    assign dout = ext0 * ext1;
endmodule

// File: rtl/exec_instr_gen_mul_arbiter.sv
// exec_instr_gen_mul_arbiter: round-robin share of one signed multiplier across NUM_REQ requesters, 2-stage pipeline
//   ap_clk     : clock
//   ap_rst     : asynchronous active-high reset
//   req_valid  : per-requester operand-pair valid
//   req_ready  : per-requester accept (one-hot or zero)
//   req_a/b    : packed operands, slice i belongs to requester i
//   resp_valid : per-requester result valid (one-hot or zero), registered
//   resp_ready : per-requester result accept; only the bit of the held tag matters
//   resp_p     : shared product bus, registered
//   busy       : either pipeline stage occupied
module exec_instr_gen_mul_arbiter
    import exec_instr_gen_mul_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int OP_WIDTH = OP_WIDTH_DEF,
    parameter int P_WIDTH  = P_WIDTH_DEF
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*OP_WIDTH-1:0]  req_a,
    input  logic [NUM_REQ*OP_WIDTH-1:0]  req_b,
    output logic [NUM_REQ-1:0]           resp_valid,
    input  logic [NUM_REQ-1:0]           resp_ready,
    output logic [P_WIDTH-1:0]           resp_p,
    output logic                         busy
);
    if (OP_WIDTH != OP_WIDTH_DEF || P_WIDTH != 2 * OP_WIDTH || NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_param
        $error("exec_instr_gen_mul_arbiter: unsupported parameter combination");
    end

    stage_t               s1, s2;
    logic [TAG_W-1:0]     last_grant;
    logic [NUM_REQ-1:0]   gnt;
    logic [TAG_W-1:0]     gidx;
    logic [OP_WIDTH-1:0]  a_sel, b_sel;
    logic [P_WIDTH-1:0]   prod;
    logic                 s2_drain, s1_adv, s1_can;

    // Round-robin search from last_grant+1; descending k so the nearest valid requester wins.
    always_comb begin
        int j;
        j    = 0;
        gnt  = '0;
        gidx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = (int'(last_grant) + k) % NUM_REQ;
            if (req_valid[j]) begin
                gnt  = NUM_REQ'(1) << j;
                gidx = TAG_W'(j);
            end
        end
    end

    assign a_sel = OP_WIDTH'(req_a >> (int'(gidx) * OP_WIDTH));
    assign b_sel = OP_WIDTH'(req_b >> (int'(gidx) * OP_WIDTH));

    assign resp_valid = s2.valid ? NUM_REQ'(tag_onehot(s2.tag)) : '0;
    assign resp_p     = P_WIDTH'(s2.payload);
    assign busy       = s1.valid | s2.valid;

    // Only the held tag's resp_ready can drain S2, since resp_valid is one-hot on that tag.
    assign s2_drain  = |(resp_valid & resp_ready);
    assign s1_adv    = s1.valid && (!s2.valid || s2_drain);
    assign s1_can    = !s1.valid || s1_adv;
    // Gated by ap_rst so nothing is offered while the stages are being cleared.
    assign req_ready = (s1_can && !ap_rst) ? gnt : '0;

    ExecInstrGen_mul_mul_16ns_16ns_32_1_1 #(
        .din0_WIDTH(OP_WIDTH),
        .din1_WIDTH(OP_WIDTH),
        .dout_WIDTH(P_WIDTH)
    ) u_mul (
        .din0(s1.payload[2*OP_WIDTH-1:OP_WIDTH]),
        .din1(s1.payload[OP_WIDTH-1:0]),
        .dout(prod)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            s1         <= '0;
            s2         <= '0;
            last_grant <= TAG_W'(NUM_REQ - 1);
        end else begin
            if (s1_adv)
                s2 <= '{valid: 1'b1, tag: s1.tag, payload: P_WIDTH_DEF'(prod)};
            else if (s2_drain)
                s2.valid <= 1'b0;
            if (|req_ready) begin
                s1         <= '{valid: 1'b1, tag: gidx, payload: P_WIDTH_DEF'({a_sel, b_sel})};
                last_grant <= gidx;
            end else if (s1_adv)
                s1.valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_exec_instr_gen_mul_arbiter.sv
// tb_exec_instr_gen_mul_arbiter: vector table, directed corner sequences and random traffic against a scoreboard
module tb_exec_instr_gen_mul_arbiter;
    localparam int N  = 2;
    localparam int W  = 16;
    localparam int PW = 32;

    logic              ap_clk = 1'b0;
    logic              ap_rst = 1'b0;
    logic [N-1:0]      req_valid = '0, req_ready, resp_valid, resp_ready = '0;
    logic [N*W-1:0]    req_a = '0, req_b = '0;
    logic [PW-1:0]     resp_p;
    logic              busy;

    always #5 ap_clk = ~ap_clk;

    exec_instr_gen_mul_arbiter #(.NUM_REQ(N), .OP_WIDTH(W), .P_WIDTH(PW)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_p(resp_p), .busy(busy)
    );

    typedef struct { int tag; logic [PW-1:0] p; } exp_t;
    typedef struct { int req; logic [W-1:0] a; logic [W-1:0] b; logic [PW-1:0] p; } vec_t;

    exp_t         sbq[$];
    int           grants[$];
    int           resp_tags[$];
    int           checks = 0, passes = 0;
    int           tcount = 0, resp_cnt = 0, acc_cnt = 0, resp_tick = 0;
    logic [PW-1:0] last_resp_p;
    logic [N-1:0] pv = '0;
    logic [W-1:0] pa[N], pb[N];

    task automatic check(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint m;
        m = longint'($signed(a)) * longint'($signed(b));
        return m[PW-1:0];
    endfunction

    // One clock: drive pending requests, score handshakes at negedge, return 1 unit after the edge.
    task automatic tick();
        logic [N-1:0] acc;
        exp_t e;
        req_valid = pv;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = pa[i];
            req_b[i*W +: W] = pb[i];
        end
        @(negedge ap_clk);
        acc = req_valid & req_ready;
        check("ready_onehot", PW'($countones(req_ready) <= 1), 1);
        for (int i = 0; i < N; i++) begin
            if (resp_valid[i] && resp_ready[i]) begin
                if (sbq.size() == 0) check("resp_unexpected", 1, 0);
                else begin
                    e = sbq.pop_front();
                    check("resp_tag", PW'(i), PW'(e.tag));
                    check("resp_p", resp_p, e.p);
                end
                resp_cnt++;
                resp_tick = tcount;
                last_resp_p = resp_p;
                resp_tags.push_back(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                sbq.push_back('{tag: i, p: model(pa[i], pb[i])});
                grants.push_back(i);
                acc_cnt++;
            end
        end
        @(posedge ap_clk);
        #1;
        tcount++;
        pv &= ~acc;
    endtask

    task automatic drain();
        int n;
        n = 0;
        resp_ready = '1;
        while ((pv != 0 || sbq.size() != 0 || busy) && n < 60) begin
            tick();
            n++;
        end
        check("drain_done", PW'(pv == 0 && sbq.size() == 0 && !busy), 1);
    endtask

    vec_t vecs[7];

    initial begin
        int t0, r0, g0, idx;
        vecs[0] = '{0, 16'd3,    16'hFFFB, 32'hFFFFFFF1};
        vecs[1] = '{0, 16'h8000, 16'h8000, 32'h40000000};
        vecs[2] = '{1, 16'h7FFF, 16'h8000, 32'hC0008000};
        vecs[3] = '{0, 16'h0000, 16'h1234, 32'h00000000};
        vecs[4] = '{1, 16'hFFFF, 16'hFFFF, 32'h00000001};
        vecs[5] = '{1, 16'h7FFF, 16'h7FFF, 32'h3FFF0001};
        vecs[6] = '{0, 16'd100,  16'hFF9C, 32'hFFFFD8F0};
        for (int i = 0; i < N; i++) begin pa[i] = '0; pb[i] = '0; end

        #1 ap_rst = 1'b1;
        req_valid = '1;
        repeat (2) @(posedge ap_clk);
        #1;
        check("rst_req_ready", PW'(req_ready), 0);
        check("rst_resp_valid", PW'(resp_valid), 0);
        check("rst_resp_p", resp_p, 0);
        check("rst_busy", PW'(busy), 0);
        ap_rst = 1'b0;
        req_valid = '0;

        resp_ready = '1;
        for (int n = 0; n < 7; n++) begin
            pv[vecs[n].req] = 1'b1;
            pa[vecs[n].req] = vecs[n].a;
            pb[vecs[n].req] = vecs[n].b;
            t0 = tcount;
            r0 = resp_cnt;
            tick();
            check($sformatf("vec%0d_accepted", n), PW'(pv), 0);
            for (int k = 0; k < 6 && resp_cnt == r0; k++) tick();
            check($sformatf("vec%0d_latency", n), PW'(resp_tick - t0), 2);
            check($sformatf("vec%0d_p", n), last_resp_p, vecs[n].p);
        end
        drain();

        grants.delete();
        r0 = resp_cnt;
        for (int k = 0; k < 8; k++) begin
            pv = '1;
            for (int i = 0; i < N; i++) begin pa[i] = W'($urandom); pb[i] = W'($urandom); end
            tick();
        end
        check("alt_grant_count", PW'(grants.size()), 8);
        for (int k = 1; k < grants.size(); k++)
            check("alt_grant", PW'(grants[k]), PW'(1 - grants[k-1]));
        check("alt_throughput", PW'(resp_cnt - r0), 6);
        pv = '0;
        drain();

        resp_ready = 2'b10;
        pv[0] = 1'b1; pa[0] = 16'd7;  pb[0] = 16'd9;
        tick();
        pv[1] = 1'b1; pa[1] = 16'd11; pb[1] = 16'd13;
        tick();
        check("bp_second_accept", PW'(pv), 0);
        pv = '1;
        pa[0] = 16'd2; pb[0] = 16'd2; pa[1] = 16'd3; pb[1] = 16'd3;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_req_ready", PW'(req_ready), 0);
            check("bp_resp_valid", PW'(resp_valid), 1);
            check("bp_resp_p", resp_p, 32'd63);
        end
        idx = resp_tags.size();
        drain();
        check("bp_order0", PW'(resp_tags[idx]), 0);
        check("bp_order1", PW'(resp_tags[idx+1]), 1);

        resp_ready = '0;
        pv[0] = 1'b1; pa[0] = 16'd5; pb[0] = 16'd5;
        tick();
        pv[1] = 1'b1; pa[1] = 16'd6; pb[1] = 16'd6;
        tick();
        tick();
        check("full_busy", PW'(busy), 1);
        check("full_resp_valid", PW'(resp_valid), 1);
        ap_rst = 1'b1;
        req_valid = '1;
        #1;
        check("mid_rst_resp_valid", PW'(resp_valid), 0);
        check("mid_rst_req_ready", PW'(req_ready), 0);
        check("mid_rst_busy", PW'(busy), 0);
        check("mid_rst_resp_p", resp_p, 0);
        sbq.delete();
        pv = '0;
        req_valid = '0;
        @(posedge ap_clk);
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        resp_ready = '1;
        g0 = grants.size();
        pv = '1;
        pa[0] = 16'd4; pb[0] = 16'd4; pa[1] = 16'd8; pb[1] = 16'd8;
        tick();
        check("post_rst_first_grant", PW'(grants.size() > g0 ? grants[g0] : -1), 0);
        drain();

        r0 = resp_cnt;
        t0 = acc_cnt;
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && $urandom_range(1, 0) == 1) begin
                    pv[i] = 1'b1;
                    pa[i] = W'($urandom);
                    pb[i] = W'($urandom);
                end
            end
            resp_ready = N'($urandom);
            tick();
        end
        drain();
        check("rand_sb_empty", PW'(sbq.size()), 0);
        check("rand_resp_count", PW'(resp_cnt - r0), PW'(acc_cnt - t0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
